mac_csr_responder: RTL and testbench

- Avalon-MM-style CSR slave that terminates the MAC re-config interface. It sits at the far end of the register-bus-to-CSR converter.
- Decodes read/write requests, holds macCsrWaitRequest for a programmable number of cycles, then completes with a single-cycle ack.
- Backs a small register file: ID, control, W1C event status, IRQ mask and scratch registers. Drives an interrupt from unmasked status bits.

---
 rtl/mac_csr_pkg.sv | 21 ++
 rtl/mac_csr_regfile.sv | 110 +++++++++++
 rtl/mac_csr_responder.sv | 130 +++++++++++++
 tb/tb_mac_csr_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_csr_pkg.sv
// rtl/mac_csr_pkg.sv - shared register indices, FSM encoding and constants for the MAC CSR responder
package mac_csr_pkg;

   // Register word indices as decoded from macCsrAddress[15:0]
   localparam logic [15:0] IDX_ID         = 16'd0;
   localparam logic [15:0] IDX_CTRL       = 16'd1;
   localparam logic [15:0] IDX_STATUS     = 16'd2;
   localparam logic [15:0] IDX_IRQ_MASK   = 16'd3;
   localparam logic [15:0] IDX_ACCESS_CNT = 16'd4;

   // Returned for any read beyond the decoded register range
   localparam logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

   // Access sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } csrState_t;

endpackage

// File: rtl/mac_csr_regfile.sv
// rtl/mac_csr_regfile.sv - CSR decode, storage, W1C status and interrupt; optional MAC_CSR_ACCESS_CNT_EN counters
module mac_csr_regfile
   import mac_csr_pkg::*;
#(
   parameter int          NUM_REGS = 16,
   parameter logic [31:0] ID_VALUE = 32'h4D41_4301
) (
   input  logic        clockCore,
   input  logic        resetCore,
   input  logic [15:0] rdIndex,
   input  logic        wrEn,
   input  logic [15:0] wrIndex,
   input  logic [31:0] wrData,
`ifdef MAC_CSR_ACCESS_CNT_EN
   input  logic        cntRead,
   input  logic        cntWrite,
`endif
   input  logic [7:0]  eventIn,
   output logic [31:0] rdData,
   output logic [31:0] ctrlOut,
   output logic        irq
);

   localparam int          IW    = $clog2(NUM_REGS);
   localparam logic [15:0] LIMIT = 16'(NUM_REGS);
`ifdef MAC_CSR_ACCESS_CNT_EN
   // Index 4 is taken by the access counters, scratch starts above it
   localparam logic [15:0] SCRATCH_BASE = IDX_ACCESS_CNT + 16'd1;
`else
   localparam logic [15:0] SCRATCH_BASE = IDX_ACCESS_CNT;
`endif

   logic [31:0] ctrlReg;
   logic [7:0]  statusReg;
   logic [7:0]  maskReg;
   logic [7:0]  w1cMask;
   logic        wrHit;
   logic [31:0] scratchMem [NUM_REGS];

   // Out-of-range writes are simply dropped
   assign wrHit   = wrEn && (wrIndex < LIMIT);
   assign w1cMask = (wrHit && (wrIndex == IDX_STATUS)) ? wrData[7:0] : 8'd0;
   assign ctrlOut = ctrlReg;

`ifdef MAC_CSR_ACCESS_CNT_EN
   logic [15:0] writeCnt;
   logic [15:0] readCnt;

   // Saturating access counters; a write to the counter register clears both and is not counted
   always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) begin
         writeCnt <= 16'd0;
         readCnt  <= 16'd0;
      end else if (wrHit && (wrIndex == IDX_ACCESS_CNT)) begin
         writeCnt <= 16'd0;
         readCnt  <= 16'd0;
      end else begin
         if (cntWrite && (writeCnt != 16'hFFFF)) writeCnt <= writeCnt + 16'd1;
         if (cntRead && (readCnt != 16'hFFFF))   readCnt  <= readCnt + 16'd1;
      end
   end
`endif

   // Read decode; upper bits of STATUS and IRQ_MASK read as zero
   always_comb begin
      rdData = BAD_ADDR_DATA;
      if (rdIndex < LIMIT) begin
         if (rdIndex == IDX_ID)            rdData = ID_VALUE;
         else if (rdIndex == IDX_CTRL)     rdData = ctrlReg;
         else if (rdIndex == IDX_STATUS)   rdData = {24'd0, statusReg};
         else if (rdIndex == IDX_IRQ_MASK) rdData = {24'd0, maskReg};
`ifdef MAC_CSR_ACCESS_CNT_EN
         else if (rdIndex == IDX_ACCESS_CNT) rdData = {readCnt, writeCnt};
`endif
         else                              rdData = scratchMem[rdIndex[IW-1:0]];
      end
   end

   // CTRL and IRQ_MASK registers
   always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) begin
         ctrlReg <= 32'd0;
         maskReg <= 8'd0;
      end else begin
         if (wrHit && (wrIndex == IDX_CTRL))     ctrlReg <= wrData;
         if (wrHit && (wrIndex == IDX_IRQ_MASK)) maskReg <= wrData[7:0];
      end
   end

   // Event capture with W1C clear (a new event wins over a clear) and registered interrupt
   always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) begin
         statusReg <= 8'd0;
         irq       <= 1'b0;
      end else begin
         statusReg <= (statusReg & ~w1cMask) | eventIn;
         irq       <= |(statusReg & maskReg);
      end
   end

   // Scratch storage
   always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) begin
         for (int i = 0; i < NUM_REGS; i++) scratchMem[i] <= 32'd0;
      end else if (wrHit && (wrIndex >= SCRATCH_BASE)) begin
         scratchMem[wrIndex[IW-1:0]] <= wrData;
      end
   end

endmodule

// File: rtl/mac_csr_responder.sv
// rtl/mac_csr_responder.sv - MAC re-config CSR slave with programmable wait states; optional MAC_CSR_ACCESS_CNT_EN
module mac_csr_responder
   import mac_csr_pkg::*;
#(
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ID_VALUE    = 32'h4D41_4301
) (
   input  logic        clockCore,
   input  logic        resetCore,
   input  logic        macCsrRead,
   input  logic        macCsrWrite,
   input  logic [31:0] macCsrAddress,
   input  logic [31:0] macCsrWriteData,
   output logic [31:0] macCsrReadData,
   output logic        macCsrWaitRequest,
   input  logic [7:0]  eventIn,
   output logic [31:0] ctrlOut,
   output logic        irq
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   csrState_t   state;
   csrState_t   nextState;
   logic [3:0]  waitCnt;
   logic [15:0] capIndex;
   logic [31:0] capData;
   logic        capWrite;
   logic        reqActive;
   logic        isWriteNow;
   logic        enterAck;
   logic [15:0] rdIndex;
   logic [31:0] rdData;
   logic        wrEn;
   logic        unusedAddrHigh;

   // Upper address bits carry no meaning for this block
   assign unusedAddrHigh = ^macCsrAddress[31:16];

   assign reqActive  = macCsrRead | macCsrWrite;
   // In IDLE the request is not yet captured, so decode straight from the bus (needed when WAIT_CYCLES is 0)
   assign rdIndex    = (state == ST_IDLE) ? macCsrAddress[15:0] : capIndex;
   assign isWriteNow = (state == ST_IDLE) ? macCsrWrite : capWrite;
   assign enterAck   = (nextState == ST_ACK) && (state != ST_ACK);
   assign wrEn       = (state == ST_ACK) && capWrite;

`ifdef MAC_CSR_ACCESS_CNT_EN
   logic accessEnd;
   logic cntRead;
   logic cntWrite;

   // An access ends either with its ack or by being abandoned during WAIT; both are counted
   assign accessEnd = (state == ST_ACK) || ((state == ST_WAIT) && !reqActive);
   assign cntWrite  = accessEnd && capWrite;
   assign cntRead   = accessEnd && !capWrite;
`endif

   // Next-state logic: abort wins over completion in WAIT
   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE: if (reqActive) nextState = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
         ST_WAIT: begin
            if (!reqActive)           nextState = ST_IDLE;
            else if (waitCnt <= 4'd1) nextState = ST_ACK;
         end
         ST_ACK:  nextState = ST_IDLE;
         default: nextState = ST_IDLE;
      endcase
   end

   // State register and registered wait request, low only while in ACK
   always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) begin
         state             <= ST_IDLE;
         macCsrWaitRequest <= 1'b1;
      end else begin
         state             <= nextState;
         macCsrWaitRequest <= (nextState != ST_ACK);
      end
   end

   // Request capture and wait-state countdown
   always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) begin
         waitCnt  <= 4'd0;
         capIndex <= 16'd0;
         capData  <= 32'd0;
         capWrite <= 1'b0;
      end else if ((state == ST_IDLE) && reqActive) begin
         waitCnt  <= WAIT_INIT;
         capIndex <= macCsrAddress[15:0];
         capData  <= macCsrWriteData;
         capWrite <= macCsrWrite;
      end else if (state == ST_WAIT) begin
         waitCnt  <= (nextState == ST_WAIT) ? (waitCnt - 4'd1) : 4'd0;
      end
   end

   // Read data is registered as the access enters ACK
   always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) begin
         macCsrReadData <= 32'd0;
      end else if (enterAck && !isWriteNow) begin
         macCsrReadData <= rdData;
      end
   end

   mac_csr_regfile #(
      .NUM_REGS (NUM_REGS),
      .ID_VALUE (ID_VALUE)
   ) regfile (
      .clockCore (clockCore),
      .resetCore (resetCore),
      .rdIndex   (rdIndex),
      .wrEn      (wrEn),
      .wrIndex   (capIndex),
      .wrData    (capData),
`ifdef MAC_CSR_ACCESS_CNT_EN
      .cntRead   (cntRead),
      .cntWrite  (cntWrite),
`endif
      .eventIn   (eventIn),
      .rdData    (rdData),
      .ctrlOut   (ctrlOut),
      .irq       (irq)
   );

endmodule

// File: tb/tb_mac_csr_responder.sv
// tb/tb_mac_csr_responder.sv - table-driven self-checking bench for mac_csr_responder
module tb_mac_csr_responder;

   localparam logic [1:0] OP_RD = 2'd0;
   localparam logic [1:0] OP_WR = 2'd1;
   localparam logic [1:0] OP_RW = 2'd2;
   localparam int         EXP_LAT = 3;   // capture edge plus two wait cycles

   logic        clockCore = 1'b0;
   logic        resetCore = 1'b0;
   logic        macCsrRead = 1'b0;
   logic        macCsrWrite = 1'b0;
   logic [31:0] macCsrAddress = 32'd0;
   logic [31:0] macCsrWriteData = 32'd0;
   logic [31:0] macCsrReadData;
   logic        macCsrWaitRequest;
   logic [7:0]  eventIn = 8'd0;
   logic [31:0] ctrlOut;
   logic        irq;

   int errors = 0;
   int checks = 0;

   always #5 clockCore = ~clockCore;

   mac_csr_responder #(
      .NUM_REGS    (16),
      .WAIT_CYCLES (2),
      .ID_VALUE    (32'h4D41_4301)
   ) dut (
      .clockCore         (clockCore),
      .resetCore         (resetCore),
      .macCsrRead        (macCsrRead),
      .macCsrWrite       (macCsrWrite),
      .macCsrAddress     (macCsrAddress),
      .macCsrWriteData   (macCsrWriteData),
      .macCsrReadData    (macCsrReadData),
      .macCsrWaitRequest (macCsrWaitRequest),
      .eventIn           (eventIn),
      .ctrlOut           (ctrlOut),
      .irq               (irq)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRd;
      logic [31:0] expCtrl;
   } vec_t;

   vec_t vecs [21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // One complete bus access; returns read data seen in the ack cycle and edges to ack
   task automatic access(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [7:0] ackEvent, output logic [31:0] rdata, output int lat);
      @(negedge clockCore);
      macCsrAddress   = addr;
      macCsrWriteData = wdata;
      macCsrRead      = (op != OP_WR);
      macCsrWrite     = (op != OP_RD);
      lat = 0;
      do begin
         @(posedge clockCore);
         #1;
         lat++;
      end while (macCsrWaitRequest && lat < 40);
      rdata   = macCsrReadData;
      eventIn = ackEvent;
      @(posedge clockCore);
      #1;
      eventIn     = 8'd0;
      macCsrRead  = 1'b0;
      macCsrWrite = 1'b0;
   endtask

   task automatic doRead(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      int lat;
      access(OP_RD, addr, 32'd0, 8'd0, rd, lat);
      check({name, " latency"}, 32'(lat), 32'(EXP_LAT));
      check({name, " data"}, rd, exp);
   endtask

   task automatic doWrite(input string name, input logic [31:0] addr, input logic [31:0] data, input logic [7:0] ackEvent);
      logic [31:0] rd;
      int lat;
      access(OP_WR, addr, data, ackEvent, rd, lat);
      check({name, " latency"}, 32'(lat), 32'(EXP_LAT));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          lat;
      logic        sawAck;

      vecs[0]  = '{OP_RD, 32'h0000_0000, 32'h0,         32'h4D41_4301, 32'h0};
      vecs[1]  = '{OP_WR, 32'h0000_0001, 32'h1234_5678, 32'h0,         32'h1234_5678};
      vecs[2]  = '{OP_RD, 32'h0000_0001, 32'h0,         32'h1234_5678, 32'h1234_5678};
      vecs[3]  = '{OP_WR, 32'h0000_0005, 32'hA5A5_0001, 32'h0,         32'h1234_5678};
      vecs[4]  = '{OP_WR, 32'h0000_000F, 32'hCAFE_F00D, 32'h0,         32'h1234_5678};
      vecs[5]  = '{OP_RD, 32'h0000_0005, 32'h0,         32'hA5A5_0001, 32'h1234_5678};
      vecs[6]  = '{OP_RD, 32'h0000_000F, 32'h0,         32'hCAFE_F00D, 32'h1234_5678};
      vecs[7]  = '{OP_RD, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'h1234_5678};
      vecs[8]  = '{OP_WR, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0,         32'h1234_5678};
      vecs[9]  = '{OP_RD, 32'h0000_0000, 32'h0,         32'h4D41_4301, 32'h1234_5678};
      vecs[10] = '{OP_RD, 32'h0000_0005, 32'h0,         32'hA5A5_0001, 32'h1234_5678};
      vecs[11] = '{OP_RD, 32'h0000_0003, 32'h0,         32'h0000_0000, 32'h1234_5678};
      vecs[12] = '{OP_WR, 32'h0000_0003, 32'hFFFF_FF04, 32'h0,         32'h1234_5678};
      vecs[13] = '{OP_RD, 32'h0000_0003, 32'h0,         32'h0000_0004, 32'h1234_5678};
      vecs[14] = '{OP_RD, 32'h0000_0002, 32'h0,         32'h0000_0000, 32'h1234_5678};
      vecs[15] = '{OP_RD, 32'h0001_0001, 32'h0,         32'h1234_5678, 32'h1234_5678};
      vecs[16] = '{OP_RD, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 32'h1234_5678};
      vecs[17] = '{OP_RW, 32'h0000_0006, 32'h600D_F00D, 32'h0,         32'h1234_5678};
      vecs[18] = '{OP_RD, 32'h0000_0006, 32'h0,         32'h600D_F00D, 32'h1234_5678};
      vecs[19] = '{OP_WR, 32'h0000_0000, 32'hFFFF_0000, 32'h0,         32'h1234_5678};
      vecs[20] = '{OP_RD, 32'h0000_0000, 32'h0,         32'h4D41_4301, 32'h1234_5678};

      // Reset state
      repeat (3) @(posedge clockCore);
      #1;
      check("reset waitRequest", {31'd0, macCsrWaitRequest}, 32'd1);
      check("reset readData", macCsrReadData, 32'd0);
      check("reset ctrlOut", ctrlOut, 32'd0);
      check("reset irq", {31'd0, irq}, 32'd0);
      @(negedge clockCore);
      resetCore = 1'b1;

      // Directed vector table
      for (int i = 0; i < 21; i++) begin
         access(vecs[i].op, vecs[i].addr, vecs[i].wdata, 8'd0, rd, lat);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(EXP_LAT));
         check($sformatf("vec%0d waitRequest after ack", i), {31'd0, macCsrWaitRequest}, 32'd1);
         check($sformatf("vec%0d ctrlOut", i), ctrlOut, vecs[i].expCtrl);
         if (vecs[i].op == OP_RD)
            check($sformatf("vec%0d readData", i), rd, vecs[i].expRd);
      end

      // Event pulse with IRQ_MASK=0x04: interrupt follows STATUS by one cycle
      @(negedge clockCore);
      eventIn = 8'h05;
      @(posedge clockCore);
      #1;
      check("irq lags status", {31'd0, irq}, 32'd0);
      @(negedge clockCore);
      eventIn = 8'h00;
      @(posedge clockCore);
      #1;
      check("irq after event", {31'd0, irq}, 32'd1);
      doRead("status after event", 32'd2, 32'h0000_0005);

      // Clear of bit 2 collides with a new event on bit 2: the set wins
      doWrite("w1c collide", 32'd2, 32'h0000_0004, 8'h04);
      doRead("status after collide", 32'd2, 32'h0000_0005);
      check("irq after collide", {31'd0, irq}, 32'd1);

      // Clear everything; irq drops one cycle after STATUS does
      doWrite("w1c all", 32'd2, 32'h0000_0005, 8'h00);
      check("irq still high after clear", {31'd0, irq}, 32'd1);
      @(posedge clockCore);
      #1;
      check("irq low after clear", {31'd0, irq}, 32'd0);
      doRead("status after clear", 32'd2, 32'h0000_0000);

      // Masked event does not raise irq
      @(negedge clockCore);
      eventIn = 8'h01;
      @(negedge clockCore);
      eventIn = 8'h00;
      repeat (2) @(posedge clockCore);
      #1;
      check("masked event irq", {31'd0, irq}, 32'd0);
      doRead("status masked event", 32'd2, 32'h0000_0001);
      doWrite("w1c masked", 32'd2, 32'h0000_00FF, 8'h00);

      // Write abandoned after one wait cycle: no ack and no commit
      @(negedge clockCore);
      macCsrAddress   = 32'd1;
      macCsrWriteData = 32'hDEAD_0000;
      macCsrWrite     = 1'b1;
      @(posedge clockCore);
      #1;
      check("abort capture waitRequest", {31'd0, macCsrWaitRequest}, 32'd1);
      @(posedge clockCore);
      #1;
      check("abort wait waitRequest", {31'd0, macCsrWaitRequest}, 32'd1);
      macCsrWrite = 1'b0;
      sawAck = 1'b0;
      repeat (6) begin
         @(posedge clockCore);
         #1;
         if (!macCsrWaitRequest) sawAck = 1'b1;
      end
      check("abort no ack", {31'd0, sawAck}, 32'd0);
      check("abort ctrlOut", ctrlOut, 32'h1234_5678);
      doRead("after abort", 32'd1, 32'h1234_5678);

`ifdef MAC_CSR_ACCESS_CNT_EN
      doWrite("cnt clear", 32'd4, 32'd0, 8'h00);
      for (int i = 0; i < 3; i++) doWrite("cnt wr", 32'd5, 32'(i), 8'h00);
      for (int i = 0; i < 2; i++) doRead("cnt rd", 32'd5, 32'd2);
      doRead("access count", 32'd4, 32'h0002_0003);
      doWrite("cnt clear again", 32'd4, 32'hFFFF_FFFF, 8'h00);
      doRead("access count cleared", 32'd4, 32'h0000_0000);
      doRead("access count one read", 32'd4, 32'h0001_0000);
`else
      doWrite("scratch4 write", 32'd4, 32'h4444_0004, 8'h00);
      doRead("scratch4 read", 32'd4, 32'h4444_0004);
`endif

      // Reset during the ack cycle: wait request returns high immediately
      @(negedge clockCore);
      macCsrAddress   = 32'd1;
      macCsrWriteData = 32'hBAD0_0001;
      macCsrWrite     = 1'b1;
      lat = 0;
      do begin
         @(posedge clockCore);
         #1;
         lat++;
      end while (macCsrWaitRequest && lat < 40);
      check("pre-reset ack latency", 32'(lat), 32'(EXP_LAT));
      resetCore = 1'b0;
      #1;
      check("mid-access reset waitRequest", {31'd0, macCsrWaitRequest}, 32'd1);
      check("mid-access reset ctrlOut", ctrlOut, 32'd0);
      macCsrWrite = 1'b0;
      @(negedge clockCore);
      resetCore = 1'b1;
      repeat (2) @(posedge clockCore);
      #1;
      check("post-reset ctrlOut", ctrlOut, 32'd0);
      doRead("post-reset ctrl read", 32'd1, 32'd0);
      doRead("post-reset scratch", 32'd5, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
